// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch shared types and constants.
// Fetch-unit FSM states and widths.
package ifu_fetch_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned INST_W = 32;

  localparam logic [XLEN-1:0] DEF_RESET_PC = 32'h8000_0000;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    ERR
  } state_t;

endpackage

// File: rtl/ifu_fetch_if.sv
// ifu_fetch bus bundle: imem request/response and IF/ID handoff.
// master = fetch unit, slave = memory plus IF/ID register side.
interface ifu_fetch_if;
  import ifu_fetch_pkg::*;

  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [XLEN-1:0]   imem_req_addr;
  logic              imem_resp_valid;
  logic [INST_W-1:0] imem_resp_data;
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] Inst;
  logic [XLEN-1:0]   inst_pc;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data,
    output inst_valid,
    output Inst,
    output inst_pc,
    input  inst_ready
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data,
    input  inst_valid,
    input  Inst,
    input  inst_pc,
    output inst_ready
  );

endinterface

// File: rtl/ifu_fetch.sv
// Single-outstanding instruction fetch unit with redirect and misalign trap.
// Optional IFU_PERF_CNT_EN adds fetch_cnt (accepted-instruction counter).
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  ifu_fetch_if.master     bus,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            misalign
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]     fetch_cnt
`endif
);

  state_t state_q, state_d;

  logic [XLEN-1:0]   pc_q, pc_d;
  logic              drop_q, drop_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [XLEN-1:0]   ipc_q, ipc_d;
  logic              mis_q, mis_d;

  logic redir_ok;
  logic redir_bad;
  logic req_hs;

  assign redir_ok  = redirect && (redirect_pc[1:0] == 2'b00);
  assign redir_bad = redirect && (redirect_pc[1:0] != 2'b00);
  assign req_hs    = (state_q == REQ) && bus.imem_req_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    inst_d  = inst_q;
    ipc_d   = ipc_q;
    mis_d   = mis_q;

    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (bus.imem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (bus.imem_resp_valid) begin
          if (drop_q || redirect) begin
            drop_d  = 1'b0;
            state_d = REQ;
          end else begin
            inst_d  = bus.imem_resp_data;
            ipc_d   = pc_q;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (bus.inst_ready) begin
          pc_d    = pc_q + 32'd4;
          state_d = REQ;
        end
      end
      ERR: state_d = ERR;
      default: state_d = IDLE;
    endcase

    // Redirect overrides the sequential update; ERR is terminal.
    if (state_q != ERR) begin
      unique case (1'b1)
        redir_bad: begin
          mis_d   = 1'b1;
          state_d = ERR;
        end
        redir_ok: begin
          pc_d = redirect_pc;
          if (state_q == HOLD) state_d = REQ;
          if (req_hs) drop_d = 1'b1;
          if (state_q == WAIT && !bus.imem_resp_valid)
            drop_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      drop_q <= 1'b0;
      inst_q <= '0;
      ipc_q  <= '0;
      mis_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      drop_q <= drop_d;
      inst_q <= inst_d;
      ipc_q  <= ipc_d;
      mis_q  <= mis_d;
    end
  end

  assign bus.imem_req_valid = (state_q == REQ);
  assign bus.imem_req_addr  = pc_q;
  assign bus.inst_valid     = (state_q == HOLD);
  assign bus.Inst           = inst_q;
  assign bus.inst_pc        = ipc_q;
  assign misalign           = mis_q;

`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      fetch_cnt <= '0;
    else if (bus.inst_valid && bus.inst_ready)
      fetch_cnt <= fetch_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Scoreboard bench for ifu_fetch: memory model, request/instruction monitor.
// Covers reset, stalls, redirects in every state, misalign trap, perf counter.
module tb_ifu_fetch;
  import ifu_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        misalign;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt;
`endif

  ifu_fetch_if bus();

  ifu_fetch #(.RESET_PC(32'h8000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .misalign    (misalign)
`ifdef IFU_PERF_CNT_EN
    ,
    .fetch_cnt   (fetch_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int resp_lat = 1;

  logic [31:0] exp_req_q[$];
  logic [63:0] exp_inst_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], 16'h0013};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_inst(input logic [31:0] p);
    exp_inst_q.push_back({mem_word(p), p});
  endtask

  task automatic wait_inst(input logic [31:0] w, input logic [31:0] p,
                           input string name);
    int n = 0;
    bit found = 0;
    while (!found && n < 60) begin
      @(negedge clk);
      if (bus.inst_valid) begin
        found = 1;
        chk({name, "_word"}, bus.Inst, w);
        chk({name, "_pc"}, bus.inst_pc, p);
      end
      n++;
      step();
    end
    if (!found) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no inst_valid want one", name);
    end
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    bit found = 0;
    while (!found && n < 60) begin
      @(negedge clk);
      if (bus.imem_req_valid && bus.imem_req_ready) found = 1;
      n++;
      step();
    end
    if (!found) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no request want one", name);
    end
  endtask

  // Memory: one response resp_lat cycles after the accepting edge.
  initial begin
    logic        hs;
    logic        r;
    logic [31:0] a;
    logic [31:0] pend;
    int          cnt;
    cnt = 0;
    pend = 32'h0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = 32'h0;
    forever begin
      @(negedge clk);
      hs = bus.imem_req_valid && bus.imem_req_ready;
      a  = bus.imem_req_addr;
      r  = rst;
      @(posedge clk);
      #1;
      bus.imem_resp_valid = 1'b0;
      if (r) begin
        cnt = 0;
      end else begin
        if (hs) begin
          cnt  = resp_lat;
          pend = mem_word(a);
        end
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_data  = pend;
          end
        end
      end
    end
  end

  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (!rst && bus.imem_req_valid && bus.imem_req_ready) begin
        if (exp_req_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL req_unexpected: got addr %h want none",
                   bus.imem_req_addr);
        end else begin
          chk("req_addr", bus.imem_req_addr, exp_req_q.pop_front());
        end
      end
      if (!rst && bus.inst_valid && bus.inst_ready) begin
        if (exp_inst_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL inst_unexpected: got %h@%h want none",
                   bus.Inst, bus.inst_pc);
        end else begin
          e = exp_inst_q.pop_front();
          chk("inst_word", bus.Inst, e[63:32]);
          chk("inst_pc", bus.inst_pc, e[31:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] p;
    logic [31:0] nxt;
    int n;
    bus.imem_req_ready = 1'b1;
    bus.inst_ready     = 1'b0;

    // Reset values
    repeat (3) step();
    @(negedge clk);
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("rst_req_addr", bus.imem_req_addr, 32'h8000_0000);
    chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("rst_inst", bus.Inst, 32'h0);
    chk("rst_inst_pc", bus.inst_pc, 32'h0);
    chk("rst_misalign", 32'(misalign), 32'd0);

    // First fetch and latencies
    exp_req_q.push_back(32'h8000_0000);
    push_inst(32'h8000_0000);
    exp_req_q.push_back(32'h8000_0004);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("idle_cycle", 32'(bus.imem_req_valid), 32'd0);
    step();
    @(negedge clk);
    chk("first_req_valid", 32'(bus.imem_req_valid), 32'd1);
    step();
    @(negedge clk);
    chk("no_early_inst", 32'(bus.inst_valid), 32'd0);
    step();
    bus.inst_ready = 1'b1;
    @(negedge clk);
    chk("inst_latency", 32'(bus.inst_valid), 32'd1);
    step();
    bus.inst_ready = 1'b0;
    wait_inst(32'h0004_0013, 32'h8000_0004, "second");

    // HOLD stall keeps outputs stable, no new request
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(bus.inst_valid), 32'd1);
      chk("stall_inst", bus.Inst, 32'h0004_0013);
      chk("stall_pc", bus.inst_pc, 32'h8000_0004);
      chk("stall_noreq", 32'(bus.imem_req_valid), 32'd0);
      step();
    end
    push_inst(32'h8000_0004);
    exp_req_q.push_back(32'h8000_0008);
    bus.inst_ready = 1'b1;
    step();
    bus.inst_ready = 1'b0;
    wait_inst(32'h0008_0013, 32'h8000_0008, "after_stall");

    // Redirect during WAIT before the response
    push_inst(32'h8000_0008);
    exp_req_q.push_back(32'h8000_000C);
    resp_lat = 3;
    bus.inst_ready = 1'b1;
    step();
    bus.inst_ready = 1'b0;
    wait_req("wait_redir");
    redirect = 1'b1;
    redirect_pc = 32'h8000_0100;
    exp_req_q.push_back(32'h8000_0100);
    step();
    redirect = 1'b0;
    wait_inst(32'h0100_0013, 32'h8000_0100, "wait_redir");

    // Redirect coincident with the response
    resp_lat = 1;
    push_inst(32'h8000_0100);
    exp_req_q.push_back(32'h8000_0104);
    bus.inst_ready = 1'b1;
    step();
    bus.inst_ready = 1'b0;
    wait_req("resp_redir");
    redirect = 1'b1;
    redirect_pc = 32'h8000_0200;
    exp_req_q.push_back(32'h8000_0200);
    step();
    redirect = 1'b0;
    wait_inst(32'h0200_0013, 32'h8000_0200, "resp_redir");

    // Redirect in HOLD with same-cycle consume
    push_inst(32'h8000_0200);
    exp_req_q.push_back(32'h8000_0300);
    redirect = 1'b1;
    redirect_pc = 32'h8000_0300;
    bus.inst_ready = 1'b1;
    step();
    redirect = 1'b0;
    bus.inst_ready = 1'b0;
    @(negedge clk);
    chk("hold_redir_drop", 32'(bus.inst_valid), 32'd0);
    step();
    wait_inst(32'h0300_0013, 32'h8000_0300, "hold_redir");

    // Redirect in REQ without a handshake
    bus.imem_req_ready = 1'b0;
    push_inst(32'h8000_0300);
    bus.inst_ready = 1'b1;
    step();
    bus.inst_ready = 1'b0;
    @(negedge clk);
    chk("req_stall_addr", bus.imem_req_addr, 32'h8000_0304);
    step();
    redirect = 1'b1;
    redirect_pc = 32'h8000_0400;
    exp_req_q.push_back(32'h8000_0400);
    @(negedge clk);
    chk("req_redir_hold", bus.imem_req_addr, 32'h8000_0304);
    step();
    redirect = 1'b0;
    @(negedge clk);
    chk("req_redir_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("req_redir_addr", bus.imem_req_addr, 32'h8000_0400);
    step();
    bus.imem_req_ready = 1'b1;
    wait_inst(32'h0400_0013, 32'h8000_0400, "req_redir");

    // Misaligned redirect traps until reset
    redirect = 1'b1;
    redirect_pc = 32'h8000_0102;
    step();
    redirect = 1'b0;
    @(negedge clk);
    chk("misalign_set", 32'(misalign), 32'd1);
`ifdef IFU_PERF_CNT_EN
    chk("cnt_six", fetch_cnt, 32'd6);
`endif
    step();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("err_quiet", {30'd0, bus.imem_req_valid, bus.inst_valid},
          32'd0);
      step();
    end
    rst = 1'b1;
    step();
    step();
    @(negedge clk);
    chk("err_rst_misalign", 32'(misalign), 32'd0);
    chk("err_rst_addr", bus.imem_req_addr, 32'h8000_0000);
`ifdef IFU_PERF_CNT_EN
    chk("cnt_rst", fetch_cnt, 32'd0);
`endif
    step();
    rst = 1'b0;
    exp_req_q.push_back(32'h8000_0000);
    wait_inst(32'h0000_0013, 32'h8000_0000, "err_restart");

    // Ten accepted instructions, one via redirect
    p = 32'h8000_0000;
    for (int i = 0; i < 10; i++) begin
      push_inst(p);
      nxt = (i == 4) ? 32'h8000_0800 : p + 32'd4;
      exp_req_q.push_back(nxt);
      if (i == 4) begin
        redirect = 1'b1;
        redirect_pc = nxt;
      end
      bus.inst_ready = 1'b1;
      step();
      bus.inst_ready = 1'b0;
      redirect = 1'b0;
      wait_inst(mem_word(nxt), nxt, "run");
      p = nxt;
    end
`ifdef IFU_PERF_CNT_EN
    @(negedge clk);
    chk("cnt_ten", fetch_cnt, 32'd10);
    step();
`endif

    // Reset mid-WAIT with the drop flag armed
    push_inst(p);
    exp_req_q.push_back(p + 32'd4);
    resp_lat = 3;
    bus.inst_ready = 1'b1;
    step();
    bus.inst_ready = 1'b0;
    wait_req("midwait");
    redirect = 1'b1;
    redirect_pc = 32'h8000_0900;
    step();
    redirect = 1'b0;
    rst = 1'b1;
    resp_lat = 1;
    step();
    step();
    @(negedge clk);
    chk("midrst_inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("midrst_req_valid", 32'(bus.imem_req_valid), 32'd0);
`ifdef IFU_PERF_CNT_EN
    chk("midrst_cnt", fetch_cnt, 32'd0);
`endif
    step();
    rst = 1'b0;
    exp_req_q.push_back(32'h8000_0000);
    wait_inst(32'h0000_0013, 32'h8000_0000, "midrst_restart");

    n = 0;
    while ((exp_req_q.size() != 0 || exp_inst_q.size() != 0) && n < 50) begin
      step();
      n++;
    end
    total++;
    if (exp_req_q.size() != 0 || exp_inst_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d req %0d inst pending want 0",
               exp_req_q.size(), exp_inst_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
